// File: rtl/logic16_arbiter_pkg.sv
// Shared definitions for the two-requester bitwise logic arbiter.
package logic16_arbiter_pkg;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned OP_W  = 2;

  // Opcode encoding for the bitwise unit.
  typedef enum logic [OP_W-1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOT = 2'b11
  } op_e;

  // Arbiter FSM state encoding.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_e;

  // Requester identifiers carried on rsp_id.
  localparam logic ID_REQ0 = 1'b0;
  localparam logic ID_REQ1 = 1'b1;

  // Latched operation payload.
  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } req_t;

endpackage

// File: rtl/and16.sv
// 16-bit AND gate bank.
// Ports: a, b - operands; y - a & b.
module and16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y
);
  assign y = a & b;
endmodule

// File: rtl/bitwise_unit.sv
// Combinational bitwise logic unit built from the 16-bit gate banks.
// Ports: op - opcode (AND/OR/XOR/NOT); a, b - operands (b ignored for NOT);
//        y - selected result.
module bitwise_unit
  import logic16_arbiter_pkg::*;
(
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] y_and;
  logic [WIDTH-1:0] y_or;
  logic [WIDTH-1:0] y_xor;
  logic [WIDTH-1:0] y_not;

  and16 u_and (.a(a), .b(b), .y(y_and));
  or16  u_or  (.a(a), .b(b), .y(y_or));
  xor16 u_xor (.a(a), .b(b), .y(y_xor));
  not16 u_not (.a(a),        .y(y_not));

  // Result select.
  always_comb begin
    y = y_and;
    case (op)
      OP_AND:  y = y_and;
      OP_OR:   y = y_or;
      OP_XOR:  y = y_xor;
      OP_NOT:  y = y_not;
      default: y = y_and;
    endcase
  end

endmodule

// File: rtl/not16.sv
// 16-bit inverter bank.
// Ports: a - operand; y - ~a.
module not16 (
  input  logic [15:0] a,
  output logic [15:0] y
);
  assign y = ~a;
endmodule

// File: rtl/or16.sv
// 16-bit OR gate bank.
// Ports: a, b - operands; y - a | b.
module or16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y
);
  assign y = a | b;
endmodule

// File: rtl/xor16.sv
// 16-bit XOR gate bank.
// Ports: a, b - operands; y - a ^ b.
module xor16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y
);
  assign y = a ^ b;
endmodule

// File: rtl/logic16_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit between two requesters.
// Ports: clk, rst_n (async active-low);
//        req0_*/req1_* - valid/ready request ports with op, a, b payload;
//        rsp_valid/rsp_ready - registered response handshake;
//        rsp_id - requester that issued the result; rsp_data - result word.
module logic16_arbiter
  import logic16_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OP_W-1:0]  req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OP_W-1:0]  req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data
);

  state_e           state_q;
  state_e           state_d;
  logic             sel_c;
  logic             hs_c;
  req_t             req_q;
  logic             id_q;
  logic             last_grant_q;
  logic             rsp_valid_q;
  logic             rsp_id_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic [WIDTH-1:0] unit_y;

  bitwise_unit u_unit (
    .op (req_q.op),
    .a  (req_q.a),
    .b  (req_q.b),
    .y  (unit_y)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hs_c) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant select and combinational ready; a tie goes to the requester not served last.
  always_comb begin
    sel_c = ID_REQ0;
    if (req0_valid && req1_valid) sel_c = ~last_grant_q;
    else if (req1_valid)          sel_c = ID_REQ1;
    req0_ready = rst_n && (state_q == IDLE) && req0_valid && (sel_c == ID_REQ0);
    req1_ready = rst_n && (state_q == IDLE) && req1_valid && (sel_c == ID_REQ1);
    hs_c       = req0_ready || req1_ready;
  end

  // Operand capture, round-robin pointer and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q        <= '0;
      id_q         <= ID_REQ0;
      last_grant_q <= ID_REQ1;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= ID_REQ0;
      rsp_data_q   <= '0;
    end else begin
      if (hs_c) begin
        req_q        <= sel_c ? req_t'{req1_op, req1_a, req1_b}
                              : req_t'{req0_op, req0_a, req0_b};
        id_q         <= sel_c;
        last_grant_q <= sel_c;
      end
      if (state_q == EXEC) begin
        rsp_valid_q <= 1'b1;
        rsp_id_q    <= id_q;
        rsp_data_q  <= unit_y;
      end else if ((state_q == RESP) && rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_logic16_arbiter.sv
// Scoreboard bench for logic16_arbiter: directed operations push expected
// responses; a negedge monitor pops and compares on each response handshake.
module tb_logic16_arbiter;
  import logic16_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [1:0]  req0_op, req1_op;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [15:0] rsp_data;

  logic16_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        id;
    logic [15:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned rsp_cyc[$];
  int unsigned cyc = 0;
  int          n_pass = 0;
  int          n_checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_now(input string name, input int val);
    n_checks++;
    $display("FAIL %s: value %0d", name, val);
  endtask

  // Response monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid && rsp_ready) begin
        rsp_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          fail_now("unexpected_rsp", int'(rsp_data));
        end else begin
          e = exp_q.pop_front();
          chk("rsp_id", 32'(rsp_id), 32'(e.id));
          chk("rsp_data", 32'(rsp_data), 32'(e.data));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one request (called at posedge+1); returns at posedge+1 after its handshake.
  task automatic issue(input bit id, input logic [1:0] op, input logic [15:0] a,
                       input logic [15:0] b);
    bit done = 1'b0;
    if (id == 1'b0) begin req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1; end
    else            begin req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1; end
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if ((id == 1'b0 && req0_ready) || (id == 1'b1 && req1_ready)) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    if (!done) fail_now("issue_timeout", int'(id));
    if (id == 1'b0) req0_valid = 1'b0;
    else            req1_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) fail_now("drain_timeout", exp_q.size());
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op = 2'b00; req0_a = 16'h0; req0_b = 16'h0;
    req1_op = 2'b00; req1_a = 16'h0; req1_b = 16'h0;
    rsp_ready = 1'b1;

    // Reset state, with a request pending to show ready is held low.
    #3;
    req0_valid = 1'b1;
    #1;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_id", 32'(rsp_id), 32'd0);
    chk("reset_rsp_data", 32'(rsp_data), 32'd0);
    chk("reset_req0_ready", 32'(req0_ready), 32'd0);
    req0_valid = 1'b0;
    do_reset();

    // 1: req0 OR, latency check.
    exp_q.push_back(exp_t'{1'b0, 16'h4B44});
    req0_op = OP_OR; req0_a = 16'd18500; req0_b = 16'd19264; req0_valid = 1'b1;
    @(negedge clk);
    chk("t1_req0_ready", 32'(req0_ready), 32'd1);
    chk("t1_req1_ready", 32'(req1_ready), 32'd0);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    @(negedge clk);
    chk("t1_rsp_valid_t1", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("t1_rsp_valid_t2", 32'(rsp_valid), 32'd1);
    wait_drain();

    // 2: continuous contention alternates 0,1,0,1 from reset.
    do_reset();
    exp_q.push_back(exp_t'{1'b0, 16'd2368});
    exp_q.push_back(exp_t'{1'b1, 16'd2368});
    exp_q.push_back(exp_t'{1'b0, 16'd2368});
    exp_q.push_back(exp_t'{1'b1, 16'd2368});
    fork
      begin
        issue(1'b0, OP_AND, 16'd2384, 16'd2370);
        issue(1'b0, OP_AND, 16'd2384, 16'd2370);
      end
      begin
        issue(1'b1, OP_AND, 16'd2370, 16'd2384);
        issue(1'b1, OP_AND, 16'd2370, 16'd2384);
      end
    join
    wait_drain();

    // 3: req1 XOR with a negative operand.
    exp_q.push_back(exp_t'{1'b1, 16'hA992});
    issue(1'b1, OP_XOR, 16'd8400, 16'h8942);
    wait_drain();

    // 4: response back-pressure.
    rsp_ready = 1'b0;
    exp_q.push_back(exp_t'{1'b0, 16'hFF00});
    issue(1'b0, OP_NOT, 16'h00FF, 16'h1234);
    exp_q.push_back(exp_t'{1'b1, 16'h1234});
    req1_op = OP_AND; req1_a = 16'hFFFF; req1_b = 16'h1234; req1_valid = 1'b1;
    req0_valid = 1'b1;
    @(negedge clk);
    chk("t4_exec_ready1", 32'(req1_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold_valid", 32'(rsp_valid), 32'd1);
      chk("t4_hold_data", 32'(rsp_data), 32'hFF00);
      chk("t4_hold_ready", 32'({req0_ready, req1_ready}), 32'd0);
    end
    req0_valid = 1'b0;
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("t4_resp_ready1", 32'(req1_ready), 32'd0);
    @(negedge clk);
    chk("t4_idle_ready1", 32'(req1_ready), 32'd1);
    @(posedge clk);
    #1;
    req1_valid = 1'b0;
    wait_drain();

    // 5: async reset while a response is pending.
    rsp_ready = 1'b0;
    issue(1'b1, OP_XOR, 16'hF0F0, 16'h0FF0);
    for (int i = 0; i < 10 && !rsp_valid; i++) @(negedge clk);
    chk("t5_pending_valid", 32'(rsp_valid), 32'd1);
    chk("t5_pending_id", 32'(rsp_id), 32'd1);
    chk("t5_pending_data", 32'(rsp_data), 32'hFF00);
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(rsp_valid), 32'd0);
    chk("t5_rst_id", 32'(rsp_id), 32'd0);
    chk("t5_rst_data", 32'(rsp_data), 32'd0);
    chk("t5_rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    exp_q.push_back(exp_t'{1'b0, 16'hAAAA});
    exp_q.push_back(exp_t'{1'b1, 16'h0FF0});
    fork
      issue(1'b0, OP_AND, 16'hAAAA, 16'hFFFF);
      issue(1'b1, OP_OR, 16'h0F00, 16'h00F0);
    join
    wait_drain();

    // 6: lone req1 served back-to-back every 3 cycles.
    rsp_cyc.delete();
    exp_q.push_back(exp_t'{1'b1, 16'h0003});
    exp_q.push_back(exp_t'{1'b1, 16'h0030});
    exp_q.push_back(exp_t'{1'b1, 16'h0300});
    issue(1'b1, OP_OR, 16'h0001, 16'h0002);
    issue(1'b1, OP_OR, 16'h0010, 16'h0020);
    issue(1'b1, OP_OR, 16'h0100, 16'h0200);
    wait_drain();
    chk("t6_rsp_count", 32'(rsp_cyc.size()), 32'd3);
    if (rsp_cyc.size() == 3) begin
      chk("t6_gap01", 32'(rsp_cyc[1] - rsp_cyc[0]), 32'd3);
      chk("t6_gap12", 32'(rsp_cyc[2] - rsp_cyc[1]), 32'd3);
    end

    repeat (4) @(negedge clk);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
